// File: rtl/alu_muldiv_pkg.sv
// Shared decode constants and multiply/divide FSM encoding for the EX-stage ALU.
package alu_muldiv_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_SLL   = 6'h00;
  localparam logic [5:0] FUNCT_SRL   = 6'h02;
  localparam logic [5:0] FUNCT_SRA   = 6'h03;
  localparam logic [5:0] FUNCT_SLLV  = 6'h04;
  localparam logic [5:0] FUNCT_SRLV  = 6'h06;
  localparam logic [5:0] FUNCT_SRAV  = 6'h07;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_ADDU  = 6'h21;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_SUBU  = 6'h23;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_XOR   = 6'h26;
  localparam logic [5:0] FUNCT_NOR   = 6'h27;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    MdIdle,
    MdRun,
    MdFix
  } md_state_e;

endpackage

// File: rtl/alu_muldiv_if.sv
// Issue/result bundle between the EX-stage control and the ALU.
interface alu_muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [4:0]      shamt_in;
  logic [XLEN-1:0] rrs;
  logic [XLEN-1:0] rrt_in;
  logic [15:0]     imm;
  logic            stall;
  logic            out_valid;
  logic [XLEN-1:0] rslt;
  logic            ovf;
  logic            illegal;
  logic            md_busy;

  modport master (
    output in_valid, opcode, funct, shamt_in, rrs, rrt_in, imm,
    input  stall, out_valid, rslt, ovf, illegal, md_busy
  );

  modport slave (
    input  in_valid, opcode, funct, shamt_in, rrs, rrt_in, imm,
    output stall, out_valid, rslt, ovf, illegal, md_busy
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO registers.
module muldiv_iter
  import alu_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  localparam int unsigned CW  = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            is_div_i,
  input  logic            is_signed_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            hi_we_i,
  input  logic            lo_we_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            busy_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam logic [CW-1:0] CntMax = CW'(XLEN - 1);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] wk_q, wk_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            div_q, div_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic            dz_q, dz_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;

  logic              a_neg, b_neg;
  logic [XLEN:0]     shifted, diff, sum;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    wk_d    = wk_q;
    b_d     = b_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_neg   = is_signed_i & op_a_i[XLEN-1];
    b_neg   = is_signed_i & op_b_i[XLEN-1];
    shifted = {acc_q, wk_q[XLEN-1]};
    diff    = shifted - {1'b0, b_q};
    sum     = {1'b0, acc_q} + (wk_q[0] ? {1'b0, b_q} : '0);
    prod    = {acc_q, wk_q};

    if (hi_we_i) hi_d = wdata_i;
    if (lo_we_i) lo_d = wdata_i;

    unique case (state_q)
      MdIdle: begin
        if (start_i) begin
          state_d = MdRun;
          cnt_d   = '0;
          acc_d   = '0;
          // Iterate on magnitudes; signs are reapplied in MdFix.
          wk_d    = a_neg ? -op_a_i : op_a_i;
          b_d     = b_neg ? -op_b_i : op_b_i;
          div_d   = is_div_i;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dz_d    = (op_b_i == '0);
        end
      end
      MdRun: begin
        if (div_q) begin
          if (!diff[XLEN]) begin
            acc_d = diff[XLEN-1:0];
            wk_d  = {wk_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = shifted[XLEN-1:0];
            wk_d  = {wk_q[XLEN-2:0], 1'b0};
          end
        end else begin
          acc_d = sum[XLEN:1];
          wk_d  = {sum[0], wk_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CntMax) begin
          state_d = MdFix;
          cnt_d   = '0;
        end
      end
      MdFix: begin
        state_d = MdIdle;
        if (div_q) begin
          // Divide-by-zero leaves the dividend magnitude in acc, which re-signs to the dividend.
          lo_d = dz_q ? '1 : (neg_q ? -wk_q : wk_q);
          hi_d = rneg_q ? -acc_q : acc_q;
        end else begin
          if (neg_q) prod = -prod;
          hi_d = prod[2*XLEN-1:XLEN];
          lo_d = prod[XLEN-1:0];
        end
      end
      default: state_d = MdIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MdIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      wk_q    <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      wk_q    <= wk_d;
      b_q     <= b_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_o = (state_q != MdIdle);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage integer ALU: decode, simple-op datapath, stall logic and the iterative mul/div unit.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input logic        clk,
  input logic        rst,
  alu_muldiv_if.slave bus
);

  logic            r_type, md_op, hilo_op, zext_op, accept;
  logic [XLEN-1:0] imm_sext, imm_zext, op_a, op_b, sum, diff;
  logic [SHW-1:0]  sh_amt;
  logic            add_ov, sub_ov, lt_s, lt_u;
  logic [XLEN-1:0] res;
  logic            res_ov, res_ill, res_prod;
  logic            md_busy;
  logic [XLEN-1:0] md_hi, md_lo;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] rslt_q, rslt_d;
  logic            ovf_q, ovf_d;
  logic            illegal_q, illegal_d;

  always_comb begin
    r_type  = (bus.opcode == OP_RTYPE);
    md_op   = r_type & (bus.funct inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU});
    hilo_op = r_type & (bus.funct inside {FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO});
    zext_op = bus.opcode inside {OP_ANDI, OP_ORI, OP_XORI};
  end

  // Only ops touching HI/LO or the iterative unit wait for it.
  assign bus.stall = bus.in_valid & md_busy & (md_op | hilo_op);
  assign accept    = bus.in_valid & ~bus.stall;

  assign imm_sext = XLEN'($signed(bus.imm));
  assign imm_zext = XLEN'(bus.imm);
  assign op_a     = bus.rrs;
  assign op_b     = r_type ? bus.rrt_in : (zext_op ? imm_zext : imm_sext);
  assign sh_amt   = bus.funct[2] ? bus.rrs[SHW-1:0] : SHW'(bus.shamt_in);
  assign sum      = op_a + op_b;
  assign diff     = op_a - op_b;
  assign add_ov   = (op_a[XLEN-1] == op_b[XLEN-1]) & (sum[XLEN-1] != op_a[XLEN-1]);
  assign sub_ov   = (op_a[XLEN-1] != op_b[XLEN-1]) & (diff[XLEN-1] != op_a[XLEN-1]);
  assign lt_s     = $signed(op_a) < $signed(op_b);
  assign lt_u     = op_a < op_b;

  always_comb begin
    res      = '0;
    res_ov   = 1'b0;
    res_ill  = 1'b0;
    res_prod = 1'b1;
    if (r_type) begin
      case (bus.funct)
        FUNCT_SLL, FUNCT_SLLV: res = op_b << sh_amt;
        FUNCT_SRL, FUNCT_SRLV: res = op_b >> sh_amt;
        FUNCT_SRA, FUNCT_SRAV: res = XLEN'($signed(op_b) >>> sh_amt);
        FUNCT_MFHI:            res = md_hi;
        FUNCT_MFLO:            res = md_lo;
        FUNCT_MTHI, FUNCT_MTLO, FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: res_prod = 1'b0;
        FUNCT_ADD: begin
          res    = sum;
          res_ov = add_ov;
        end
        FUNCT_ADDU:            res = sum;
        FUNCT_SUB: begin
          res    = diff;
          res_ov = sub_ov;
        end
        FUNCT_SUBU:            res = diff;
        FUNCT_AND:             res = op_a & op_b;
        FUNCT_OR:              res = op_a | op_b;
        FUNCT_XOR:             res = op_a ^ op_b;
        FUNCT_NOR:             res = ~(op_a | op_b);
        FUNCT_SLT:             res = XLEN'(lt_s);
        FUNCT_SLTU:            res = XLEN'(lt_u);
        default:               res_ill = 1'b1;
      endcase
    end else begin
      case (bus.opcode)
        OP_ADDI: begin
          res    = sum;
          res_ov = add_ov;
        end
        OP_ADDIU, OP_LW, OP_SW: res = sum;
        OP_SLTI:                res = XLEN'(lt_s);
        OP_SLTIU:               res = XLEN'(lt_u);
        OP_ANDI:                res = op_a & op_b;
        OP_ORI:                 res = op_a | op_b;
        OP_XORI:                res = op_a ^ op_b;
        default:                res_ill = 1'b1;
      endcase
    end
  end

  always_comb begin
    out_valid_d = accept & res_prod;
    rslt_d      = (accept & res_prod) ? res : rslt_q;
    ovf_d       = accept & res_prod & res_ov;
    illegal_d   = accept & res_prod & res_ill;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      rslt_q      <= '0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      rslt_q      <= rslt_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
    end
  end

  muldiv_iter #(
    .XLEN(XLEN)
  ) u_muldiv_iter (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (accept & md_op),
    .is_div_i   (bus.funct[1]),
    .is_signed_i(~bus.funct[0]),
    .op_a_i     (bus.rrs),
    .op_b_i     (bus.rrt_in),
    .hi_we_i    (accept & r_type & (bus.funct == FUNCT_MTHI)),
    .lo_we_i    (accept & r_type & (bus.funct == FUNCT_MTLO)),
    .wdata_i    (bus.rrs),
    .busy_o     (md_busy),
    .hi_o       (md_hi),
    .lo_o       (md_lo)
  );

  assign bus.out_valid = out_valid_q;
  assign bus.rslt      = rslt_q;
  assign bus.ovf       = ovf_q;
  assign bus.illegal   = illegal_q;
  assign bus.md_busy   = md_busy;

endmodule
